// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM for the 8-bit processor (opcode decode, ULA control, memory handshake with timeout).
// Optional CTRL_INSTR_COUNT_EN adds a 16-bit retired-instruction counter output.
`ifndef ULA_ADD
`define ULA_ADD 3'd0
`endif
`ifndef ULA_SUB
`define ULA_SUB 3'd1
`endif
`ifndef ULA_SLL
`define ULA_SLL 3'd2
`endif
`ifndef ULA_SRL
`define ULA_SRL 3'd3
`endif
`ifndef ULA_SLT
`define ULA_SLT 3'd4
`endif

module controle_multiciclo #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      ctrl_ula,
  output logic            sel_srcA,
  output logic [1:0]      sel_srcB,
  output logic            sel_wb,
  output logic            sel_pc,
  output logic            pc_we,
  output logic            ir_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            reg_we,
  output logic            halted,
`ifdef CTRL_INSTR_COUNT_EN
  output logic [15:0]     instr_count,
`endif
  output logic            erro
);
  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT, ERRO
  } state_t;
  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);
  state_t state, next;
  logic [3:0] wait_cnt;
  logic [2:0] r_op;
  logic mem_st, timeout;
  assign r_op = opcode == 4'd1 ? `ULA_SUB : opcode == 4'd2 ? `ULA_SLL :
                opcode == 4'd3 ? `ULA_SRL : opcode == 4'd4 ? `ULA_SLT : `ULA_ADD;
  assign mem_st = state == FETCH || state == MEM_RD || state == MEM_WR;
  assign timeout = wait_cnt == WAIT_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET;
      wait_cnt <= '0;
    end else begin
      state <= next;
      wait_cnt <= next != state ? '0 : (mem_st && !mem_ready) ? wait_cnt + 4'd1 : wait_cnt;
    end
`ifdef CTRL_INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instr_count <= '0;
    else if (next == FETCH && state != FETCH && state != RESET) instr_count <= instr_count + 16'd1;
`endif
  always_comb begin
    next = state;
    ctrl_ula = `ULA_ADD;
    sel_srcA = 1'b0;
    sel_srcB = 2'd0;
    sel_wb = 1'b0;
    sel_pc = 1'b0;
    pc_we = 1'b0;
    ir_we = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    reg_we = 1'b0;
    halted = 1'b0;
    erro = 1'b0;
    case (state)
      RESET: next = FETCH;
      FETCH: begin
        mem_rd = 1'b1;
        sel_srcA = 1'b1;
        sel_srcB = 2'd2;
        ir_we = mem_ready;
        pc_we = mem_ready;
        next = mem_ready ? DECODE : timeout ? ERRO : FETCH;
      end
      DECODE: next = opcode <= 4'd4 ? EXEC_R : opcode == 4'd5 ? EXEC_I :
                     (opcode == 4'd6 || opcode == 4'd7) ? MEM_ADDR : opcode == 4'd8 ? BRANCH :
                     opcode == 4'd9 ? JUMP : opcode == 4'hF ? HALT : ERRO;
      EXEC_R: begin
        ctrl_ula = r_op;
        next = WB_ALU;
      end
      EXEC_I: begin
        sel_srcB = 2'd1;
        next = WB_ALU;
      end
      // IR is stable here, so the ULA op of the preceding EXEC state is re-derived from opcode
      WB_ALU: begin
        ctrl_ula = opcode == 4'd5 ? `ULA_ADD : r_op;
        reg_we = 1'b1;
        next = FETCH;
      end
      MEM_ADDR: begin
        sel_srcB = 2'd1;
        next = opcode == 4'd6 ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_rd = 1'b1;
        sel_srcB = 2'd1;
        next = mem_ready ? WB_MEM : timeout ? ERRO : MEM_RD;
      end
      WB_MEM: begin
        reg_we = 1'b1;
        sel_wb = 1'b1;
        next = FETCH;
      end
      MEM_WR: begin
        mem_wr = 1'b1;
        sel_srcB = 2'd1;
        next = mem_ready ? FETCH : timeout ? ERRO : MEM_WR;
      end
      BRANCH: begin
        ctrl_ula = `ULA_SUB;
        pc_we = zero;
        next = FETCH;
      end
      JUMP: begin
        sel_pc = 1'b1;
        pc_we = 1'b1;
        next = FETCH;
      end
      HALT: halted = 1'b1;
      ERRO: erro = 1'b1;
      default: next = ERRO;
    endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized trace-based check of controle_multiciclo against per-instruction expected output sequences.
`ifndef ULA_ADD
`define ULA_ADD 3'd0
`endif
`ifndef ULA_SUB
`define ULA_SUB 3'd1
`endif
`ifndef ULA_SLL
`define ULA_SLL 3'd2
`endif
`ifndef ULA_SRL
`define ULA_SRL 3'd3
`endif
`ifndef ULA_SLT
`define ULA_SLT 3'd4
`endif

module tb_controle_multiciclo;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] ctrl_ula;
  logic sel_srcA, sel_wb, sel_pc, pc_we, ir_we, mem_rd, mem_wr, reg_we, halted, erro;
  logic [1:0] sel_srcB;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif
  int tests = 0, fails = 0;

  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ctrl_ula(ctrl_ula), .sel_srcA(sel_srcA), .sel_srcB(sel_srcB), .sel_wb(sel_wb),
    .sel_pc(sel_pc), .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .halted(halted),
`ifdef CTRL_INSTR_COUNT_EN
    .instr_count(instr_count),
`endif
    .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {logic rdy; logic [14:0] exp;} step_t;
  step_t q[$];
  logic [14:0] obs;
  assign obs = {ctrl_ula, sel_srcA, sel_srcB, sel_wb, sel_pc, pc_we, ir_we, mem_rd, mem_wr, reg_we, halted, erro};

  function automatic logic [14:0] mk(input logic [2:0] u, input logic a, input logic [1:0] b,
      input logic wb, pc, pcwe, irwe, rd, wr, rwe, h, e);
    return {u, a, b, wb, pc, pcwe, irwe, rd, wr, rwe, h, e};
  endfunction

  function automatic logic [2:0] ula_of(input logic [3:0] op);
    case (op)
      4'd1: return `ULA_SUB;
      4'd2: return `ULA_SLL;
      4'd3: return `ULA_SRL;
      4'd4: return `ULA_SLT;
      default: return `ULA_ADD;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic push(input logic r, input logic [14:0] e);
    step_t s;
    s.rdy = r;
    s.exp = e;
    q.push_back(s);
  endtask

  task automatic add_fetch(input int fw);
    for (int i = 0; i < fw; i++) push(1'b0, mk(`ULA_ADD, 1, 2'd2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push(1'b1, mk(`ULA_ADD, 1, 2'd2, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    push(rnd(), '0);
  endtask

  // Expected per-cycle outputs of one instruction, starting in FETCH
  task automatic add_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    add_fetch(fw);
    if (op <= 4'd4) begin
      push(rnd(), mk(ula_of(op), 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(rnd(), mk(ula_of(op), 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4'd5) begin
      push(rnd(), mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4'd6 || op == 4'd7) begin
      push(rnd(), mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= mw; i++)
        push(i == mw, mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, op == 4'd6, op == 4'd7, 0, 0, 0));
      if (op == 4'd6) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4'd8) push(rnd(), mk(`ULA_SUB, 0, 2'd0, 0, 0, z, 0, 0, 0, 0, 0, 0));
    else if (op == 4'd9) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic exec(input string name, input logic [3:0] op, input logic z);
    opcode = op;
    zero = z;
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      tests++;
      if (obs !== q[i].exp) begin
        fails++;
        $display("FAIL %s op=%0h step %0d: got %b expected %b", name, op, i, obs, q[i].exp);
      end
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (obs !== 15'd0) begin
      fails++;
      $display("FAIL %s: outputs %b expected all zero", name, obs);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = rnd();
    #2 check_zero("reset_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_release_cycle");
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    add_instr(4'd0, 1'b0, 0, 0);
    exec("add_after_reset", 4'd0, 1'b0);
    add_fetch(0);
    q.pop_back();
    exec("fetch_after_add", 4'd5, 1'b0);
    q.delete();
    do_reset();
  endtask

  task automatic test_alu_ops();
    for (int op = 0; op <= 5; op++) begin
      add_instr(4'(op), 1'b0, 0, 0);
      exec("alu_op", 4'(op), 1'b0);
    end
  endtask

  task automatic test_lw_sw();
    add_instr(4'd6, 1'b0, 0, 3);
    exec("lw_wait3", 4'd6, 1'b0);
    add_instr(4'd7, 1'b0, 0, 0);
    exec("sw_ready", 4'd7, 1'b0);
    add_instr(4'd6, 1'b0, 15, 15);
    exec("lw_wait_max", 4'd6, 1'b0);
    add_instr(4'd7, 1'b0, 2, 15);
    exec("sw_wait_max", 4'd7, 1'b0);
  endtask

  task automatic test_branch_jump();
    add_instr(4'd8, 1'b1, 0, 0);
    exec("beq_taken", 4'd8, 1'b1);
    add_instr(4'd8, 1'b0, 0, 0);
    exec("beq_not_taken", 4'd8, 1'b0);
    add_instr(4'd9, 1'b0, 0, 0);
    exec("jump", 4'd9, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op = 4'($urandom_range(0, 9));
      logic z = rnd();
      int fw = ($urandom % 4 == 0) ? $urandom_range(0, 15) : 0;
      int mw = ($urandom % 3 == 0) ? $urandom_range(0, 15) : 0;
      add_instr(op, z, fw, mw);
      exec("random", op, z);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) push(1'b0, mk(`ULA_ADD, 1, 2'd2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exec("fetch_timeout", 4'd0, 1'b0);
    do_reset();
    add_fetch(0);
    push(1'b0, mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) push(1'b0, mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exec("memwr_timeout", 4'd7, 1'b0);
    do_reset();
  endtask

  task automatic test_illegal_halt();
    add_fetch(0);
    for (int i = 0; i < 4; i++) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    exec("illegal_B", 4'hB, 1'b0);
    do_reset();
    add_fetch(0);
    for (int i = 0; i < 20; i++) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    exec("halt", 4'hF, 1'b0);
    do_reset();
  endtask

  task automatic test_async_reset();
    add_fetch(0);
    push(1'b0, mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, mk(`ULA_ADD, 0, 2'd1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    exec("sw_before_reset", 4'd7, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_wr !== 1'b1) begin
      fails++;
      $display("FAIL mid_memwr: mem_wr %b expected 1", mem_wr);
    end
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset_drop");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("async_reset_release");
    @(posedge clk);
    #1;
    add_instr(4'd1, 1'b0, 0, 0);
    exec("restart_after_async", 4'd1, 1'b0);
  endtask

`ifdef CTRL_INSTR_COUNT_EN
  task automatic test_instr_count();
    do_reset();
    for (int i = 0; i < 3; i++) add_instr(4'd0, 1'b0, 0, 0);
    exec("count_adds", 4'd0, 1'b0);
    add_fetch(0);
    for (int i = 0; i < 3; i++) push(rnd(), mk(`ULA_ADD, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    exec("count_halt", 4'hF, 1'b0);
    tests++;
    if (instr_count !== 16'd3) begin
      fails++;
      $display("FAIL instr_count: got %0d expected 3", instr_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_sw();
    test_branch_jump();
    test_random();
    test_async_reset();
    test_timeout();
    test_illegal_halt();
`ifdef CTRL_INSTR_COUNT_EN
    test_instr_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
